// File: rtl/seq_divider.sv
// Multicycle restoring divider: one quotient bit per clock, signed/unsigned,
// quotient to resultLow (LO), remainder to resultHigh (HI).
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             DivStart,
  input  logic             SignedMode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             DivDone,
  output logic             DivZero,
  output logic [WIDTH-1:0] resultHigh,
  output logic [WIDTH-1:0] resultLow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             a_neg, b_neg, fits;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  always_comb begin
    a_neg   = SignedMode & A[WIDTH-1];
    b_neg   = SignedMode & B[WIDTH-1];
    shifted = {rem_q, quo_q[WIDTH-1]};
    // The compare is the sign of the (WIDTH+1)-bit trial; when it fits,
    // the difference is below the divisor, so WIDTH bits hold it exactly.
    fits    = shifted >= {1'b0, dvs_q};
    trial   = shifted[WIDTH-1:0] - dvs_q;

    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (DivStart) begin
          if (B == '0) begin
            lo_d    = '1;
            hi_d    = A;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            quo_d   = a_neg ? -A : A;
            dvs_d   = b_neg ? -B : B;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = fits ? trial : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy       = (state_q == S_RUN) || (state_q == S_FIX);
  assign DivDone    = (state_q == S_DONE);
  assign DivZero    = dz_q;
  assign resultHigh = hi_q;
  assign resultLow  = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Random + directed bench for seq_divider at WIDTH=32 and WIDTH=8, checked
// against plain-arithmetic division.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s32, sm32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        s8, sm8, busy8, done8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .Reset(rst), .DivStart(s32), .SignedMode(sm32), .A(a32), .B(b32),
    .Busy(busy32), .DivDone(done32), .DivZero(dz32),
    .resultHigh(hi32), .resultLow(lo32)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .Reset(rst), .DivStart(s8), .SignedMode(sm8), .A(a8), .B(b8),
    .Busy(busy8), .DivDone(done8), .DivZero(dz8),
    .resultHigh(hi8), .resultLow(lo8)
  );

  logic        sel8;
  logic        c_busy, c_done, c_dz;
  logic [63:0] c_hi, c_lo;
  assign c_busy = sel8 ? busy8 : busy32;
  assign c_done = sel8 ? done8 : done32;
  assign c_dz   = sel8 ? dz8   : dz32;
  assign c_hi   = sel8 ? {56'b0, hi8} : {32'b0, hi32};
  assign c_lo   = sel8 ? {56'b0, lo8} : {32'b0, lo32};

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Quotient truncates toward zero, remainder follows the dividend.
  function automatic void ref_div(input int w, input logic sm, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r);
    logic [63:0] m;
    longint      sa, sb;
    m = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      q = m;
      r = a;
    end else if (!sm) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = a[w-1] ? longint'(a | ~m) : longint'(a);
      sb = b[w-1] ? longint'(b | ~m) : longint'(b);
      q  = 64'(sa / sb) & m;
      r  = 64'(sa % sb) & m;
    end
  endfunction

  task automatic do_div(input bit w8, input logic sm, input logic [63:0] a_in,
                        input logic [63:0] b_in);
    int          w, n;
    logic [63:0] m, a, b, eq, er;
    bit          busy_bad;
    w = w8 ? 8 : 32;
    m = (64'd1 << w) - 64'd1;
    a = a_in & m;
    b = b_in & m;
    ref_div(w, sm, a, b, eq, er);
    sel8 = w8;
    @(negedge clk);
    if (w8) begin
      s8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s32 = 1'b1; sm32 = sm; a32 = a[31:0]; b32 = b[31:0];
    end
    @(posedge clk); #1;
    s8 = 1'b0; s32 = 1'b0;
    // operands are free to change once accepted
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom);
    n = 1;
    busy_bad = 1'b0;
    while (!c_done && n < 200) begin
      if (!c_busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), (b == 64'd0) ? 64'd1 : 64'(w + 2));
    chk("busy_run", 64'(busy_bad), 64'd0);
    chk("busy_done", 64'(c_busy), 64'd0);
    chk("lo", c_lo, eq);
    chk("hi", c_hi, er);
    chk("divzero", 64'(c_dz), 64'(b == 64'd0));
    @(posedge clk); #1;
    chk("done_pulse", 64'(c_done), 64'd0);
    chk("hold_lo", c_lo, eq);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ndone;
    bit          sawdone;
    logic [31:0] rlo, rhi;
    rst = 1'b1; sel8 = 1'b0;
    s32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    s8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_dz32", 64'(dz32), 64'd0);
    chk("rst_lohi32", {hi32, lo32}, 64'd0);
    chk("rst_all8", {43'd0, busy8, done8, dz8, hi8, lo8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(0, 0, 100, 7);
    do_div(0, 1, 32'hFFFFFFF9, 2);
    chk("s_m7_2_lo", {32'b0, lo32}, 64'hFFFFFFFD);
    do_div(0, 0, 32'hFFFFFFF9, 2);
    chk("u_m7_2_lo", {32'b0, lo32}, 64'h7FFFFFFC);
    do_div(0, 0, 32'h1234, 0);
    do_div(0, 0, 9, 3);
    do_div(0, 1, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo", {32'b0, lo32}, 64'h80000000);
    do_div(0, 1, 32'h1234, 0);
    do_div(1, 1, 8'h80, 3);
    chk("w8_lohi", {48'b0, hi8, lo8}, 64'hFED6);

    // reset in the middle of a division
    sel8 = 1'b0;
    @(negedge clk);
    s32 = 1'b1; sm32 = 1'b0; a32 = 100; b32 = 7;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_outs", {29'd0, busy32, done32, dz32, hi32 | lo32}, 64'd0);
    sawdone = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done32) sawdone = 1'b1;
    end
    chk("mid_rst_nodone", 64'(sawdone), 64'd0);
    do_div(0, 0, 100, 7);

    // second start while busy must be dropped
    @(negedge clk);
    s32 = 1'b1; sm32 = 1'b0; a32 = 100; b32 = 7;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    s32 = 1'b1; a32 = 50; b32 = 5;
    @(posedge clk); #1;
    s32 = 1'b0;
    ndone = 0; rlo = '0; rhi = '0;
    repeat (60) begin
      if (done32) begin
        ndone++;
        rlo = lo32;
        rhi = hi32;
      end
      @(posedge clk); #1;
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_result", {rhi, rlo}, {32'd2, 32'd14});

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] ra, rb;
      ra = 64'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 64'd0 : 64'($urandom);
      if ($urandom_range(0, 20) == 0) ra = 64'h80;
      if ($urandom_range(0, 20) == 0) rb = 64'hFF;
      do_div(1, 1'(i), ra, rb);
    end
    for (int i = 0; i < 200; i++) begin
      logic [63:0] ra, rb;
      ra = 64'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : 64'($urandom);
      if ($urandom_range(0, 20) == 0) ra = 64'h80000000;
      if ($urandom_range(0, 20) == 0) rb = 64'hFFFFFFFF;
      do_div(0, 1'(i), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multicycle integer divider for the MipsCPU datapath. It is the successor to the fixed 32-bit divider and serves DIV/DIVU. It uses a restoring shift-subtract algorithm that retires one quotient bit per clock, with signed/unsigned mode, a start/done handshake and a divide-by-zero flag. The quotient is written to resultLow (LO) and the remainder to resultHigh (HI).

Parameters:
WIDTH, 32, operand/result width in bits (legal range 4..64)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
DivStart  input  1  start request, sampled only in IDLE
SignedMode  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with DivStart
A  input  WIDTH  dividend, sampled with DivStart
B  input  WIDTH  divisor, sampled with DivStart
Busy  output  1  high from the cycle after acceptance until DivDone is high
DivDone  output  1  one-cycle pulse: results valid
DivZero  output  1  high with DivDone when B was 0; holds until the next accepted start
resultHigh  output  WIDTH  remainder (HI)
resultLow  output  WIDTH  quotient (LO)

Behaviour:
- Reset: with Reset high at a rising edge, all outputs go to 0, the FSM goes to IDLE and internal registers clear. Reset overrides DivStart. Reset mid-operation aborts the division and produces no DivDone.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, DivStart=1 at edge 0:
  - Latch SignedMode and the operand signs.
  - Load |A| and |B| as magnitudes. Two's-complement negate only if SignedMode and the MSB is set.
  - Clear the remainder accumulator; set counter = WIDTH; go to RUN; Busy=1.
- IDLE with B==0 at edge 0: skip RUN and go to DONE. resultLow = all ones, resultHigh = A unmodified, DivZero=1.
- RUN, each edge:
  - Shift {rem, quo} left by 1, bringing in the quotient MSB.
  - Form trial = rem - |B| at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise restore and set quo[0] = 0.
  - Decrement the counter; on the edge where the counter reaches 0, go to FIX.
  - RUN occupies edges 1..WIDTH.
- FIX, edge WIDTH+1: apply the sign correction and register resultLow/resultHigh; go to DONE.
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
- DONE: DivDone=1 and Busy=0 for exactly one cycle, then return to IDLE.
- Latency:
  - Normal operation: DivDone is high in the cycle after edge WIDTH+1 (WIDTH+2 cycles from the start edge, 34 at WIDTH=32).
  - Divide by zero: DivDone is high in the cycle after edge 0, one cycle after the start edge.
- Signed semantics:
  - The quotient truncates toward zero and the remainder takes the sign of the dividend.
  - The invariant A = q*B + r holds modulo 2^WIDTH.
- Overflow case, MIN / -1 (signed): resultLow = MIN and resultHigh = 0. No flag is raised; this is the natural truncation result.
- DivStart while Busy or in DONE is ignored; it is not queued, and the operands in flight are unaffected.
- DivStart in the IDLE cycle immediately after DONE is accepted normally, allowing back-to-back operation.
- Results hold their values between operations. They update only at FIX or at a divide-by-zero entry into DONE.
- DivZero clears on the next accepted DivStart when B is non-zero.
- Operands A and B may change freely after the acceptance edge.

Test Plan:
- Unsigned 100/7, SignedMode=0 -> DivDone exactly 34 cycles after the start edge; resultLow=14, resultHigh=2, DivZero=0; Busy high for cycles 1..33.
- Signed -7/2 (A=0xFFFFFFF9, B=2) -> resultLow=0xFFFFFFFD (-3), resultHigh=0xFFFFFFFF (-1). Same operands with SignedMode=0 -> resultLow=0x7FFFFFFC, resultHigh=1.
- Divide by zero A=0x1234, B=0 -> DivDone one cycle after start, DivZero=1, resultLow=0xFFFFFFFF, resultHigh=0x1234. A following 9/3 clears DivZero and gives resultLow=3, resultHigh=0.
- Signed 0x80000000 / 0xFFFFFFFF -> resultLow=0x80000000, resultHigh=0, DivZero=0.
- Assert Reset at cycle 10 of 100/7 -> next cycle all outputs 0, Busy=0, and no DivDone ever. A fresh start afterwards completes normally. A second DivStart pulsed at cycle 5 of an operation is ignored, giving exactly one DivDone.
- WIDTH=8 instance: signed -128/3 -> resultLow=0xD6 (-42), resultHigh=0xFE (-2), DivDone 10 cycles after start. Randomised 1000-vector compare against a reference model in both modes.
